// File: rtl/axis_tkeep_compactor.sv
// AXI-Stream byte compactor: squeezes out null byte lanes and re-packs the
// surviving bytes, in order, into dense beats with a registered output stage.
module axis_tkeep_compactor #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] input_axis_tkeep,
  input  logic                  input_axis_tvalid,
  output logic                  input_axis_tready,
  input  logic                  input_axis_tlast,
  input  logic                  input_axis_tuser,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic [KEEP_WIDTH-1:0] output_axis_tkeep,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser
);
  localparam int K  = KEEP_WIDTH;
  localparam int CW = $clog2(2 * K) + 1;
  localparam logic [CW-1:0] K_CNT = CW'(K);

  typedef enum logic {ACCUM, FLUSH} state_t;

  state_t                  state_q;
  logic [2*DATA_WIDTH-1:0] buf_q, buf_n, base_buf;
  logic [CW-1:0]           cnt_q, cnt_n, base_cnt, emit_cnt;
  logic                    tuser_lat_q;
  logic                    slot_free, accept, emit, emit_last;
  logic [KEEP_WIDTH-1:0]   emit_keep;
  logic [DATA_WIDTH-1:0]   emit_data;

  function automatic logic [KEEP_WIDTH-1:0] lane_mask(input logic [CW-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mask_bytes(input logic [DATA_WIDTH-1:0] d,
                                                       input logic [KEEP_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < KEEP_WIDTH; i++) r[i*8 +: 8] = m[i] ? d[i*8 +: 8] : 8'h00;
    return r;
  endfunction

  assign slot_free = !output_axis_tvalid || output_axis_tready;
  // Upstream may only push while the buffer cannot overflow: below one word, or
  // when a full word leaves through the free output slot on the same edge.
  assign input_axis_tready = !rst && (state_q == ACCUM) && ((cnt_q < K_CNT) || slot_free);
  assign accept = input_axis_tvalid && input_axis_tready;

  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_cnt  = K_CNT;
    if (slot_free) begin
      if (state_q == FLUSH) begin
        emit = 1'b1;
        if (cnt_q <= K_CNT) begin
          emit_last = 1'b1;
          emit_cnt  = cnt_q;
        end
      end else if (cnt_q >= K_CNT) begin
        emit = 1'b1;
      end
    end
    emit_keep = lane_mask(emit_cnt);
    emit_data = mask_bytes(buf_q[DATA_WIDTH-1:0], emit_keep);
  end

  // Append kept input lanes, lowest first, above whatever survives this edge's emission.
  always_comb begin
    base_buf = buf_q;
    base_cnt = cnt_q;
    if (emit_last) begin
      base_cnt = '0;
    end else if (emit) begin
      base_buf = buf_q >> DATA_WIDTH;
      base_cnt = cnt_q - K_CNT;
    end
    buf_n = base_buf;
    cnt_n = base_cnt;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      if (accept && input_axis_tkeep[i]) begin
        for (int j = 0; j < 2 * K; j++) begin
          if (cnt_n == CW'(j)) buf_n[j*8 +: 8] = input_axis_tdata[i*8 +: 8];
        end
        cnt_n = cnt_n + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_n;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= ACCUM;
      cnt_q              <= '0;
      tuser_lat_q        <= 1'b0;
      output_axis_tvalid <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tkeep  <= '0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
    end else begin
      cnt_q <= cnt_n;
      if (accept && input_axis_tlast) begin
        tuser_lat_q <= input_axis_tuser;
        state_q     <= FLUSH;
      end else if (emit_last) begin
        state_q <= ACCUM;
      end
      if (slot_free) begin
        output_axis_tvalid <= emit;
        if (emit) begin
          output_axis_tdata <= emit_data;
          output_axis_tkeep <= emit_keep;
          output_axis_tlast <= emit_last;
          output_axis_tuser <= emit_last && tuser_lat_q;
        end
      end
    end
  end
endmodule

// File: doc/axis_tkeep_compactor.md
AXIS_TKEEP_COMPACTOR -- requirements
Module: axis_tkeep_compactor

Interface
REQ-001 Parameters SHALL be as follows.
- DATA_WIDTH, default 64: bus width in bits.
- KEEP_WIDTH, default DATA_WIDTH/8: byte lanes per beat, K.
REQ-002 Ports SHALL be as follows.
- clk  in  1  clock; one clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- input_axis_tdata  in  DATA_WIDTH  input bytes.
- input_axis_tkeep  in  KEEP_WIDTH  lane enables; holes allowed.
- input_axis_tvalid  in  1  input beat valid.
- input_axis_tready  out  1  input beat accepted when tvalid&tready.
- input_axis_tlast  in  1  last beat of frame.
- input_axis_tuser  in  1  frame error flag, sampled on tlast beat.
- output_axis_tdata  out  DATA_WIDTH  packed bytes.
- output_axis_tkeep  out  KEEP_WIDTH  contiguous from lane 0.
- output_axis_tvalid  out  1  output beat valid.
- output_axis_tready  in  1  downstream ready.
- output_axis_tlast  out  1  last beat of frame.
- output_axis_tuser  out  1  frame error flag, valid on tlast beat only.

Function
REQ-003 The block SHALL remove null byte lanes (tkeep=0) and emit byte-dense beats, preserving byte order: lowest set lane first, beat order preserved.
REQ-004 The block SHALL hold accepted bytes in an internal buffer of 2K bytes with a byte count C, range 0..2K-1.
REQ-005 The block SHALL have two states, ACCUM (reset state) and FLUSH.
REQ-006 The output SHALL be registered; the output slot is free when output_axis_tvalid=0 or output_axis_tready=1.
REQ-007 In ACCUM with C>=K and the slot free, the block SHALL emit the lowest K buffered bytes with tkeep all ones, tlast=0, tuser=0, then shift the buffer down by K.
REQ-008 In ACCUM, input_axis_tready SHALL be 1 when C<K, or when C>=K and the slot is free; it SHALL be 0 otherwise. This path is combinational from output_axis_tready.
REQ-009 An accepted beat SHALL append popcount(tkeep) bytes above the post-emission contents, in the same cycle as any REQ-007 emission.
REQ-010 Accepting a beat with tlast=1 SHALL latch input_axis_tuser and move the state to FLUSH.
REQ-011 In FLUSH, input_axis_tready SHALL be 0.
REQ-012 In FLUSH, on each cycle the slot is free, the block SHALL emit min(C,K) bytes with tkeep = (1<<min(C,K))-1.
REQ-013 In FLUSH, a beat emitted with C<=K SHALL carry tlast=1 and tuser equal to the latched flag, and the state SHALL return to ACCUM with C=0.
REQ-014 In FLUSH with C=0, the block SHALL emit one beat with tkeep=0, tdata=0, tlast=1 and the latched tuser. This covers empty frames and frames ending in an all-null beat after a full word was already emitted.
REQ-015 Output tdata lanes above the tkeep boundary SHALL be 0.
REQ-016 An output beat SHALL appear on output_axis_tvalid exactly one cycle after the emitting edge; a dense K-lane stream SHALL sustain one beat per cycle with output_axis_tready held at 1.
REQ-017 Output registers SHALL hold their values while output_axis_tvalid=1 and output_axis_tready=0.
REQ-018 Inputs with tvalid=0 SHALL be ignored regardless of the other input signals.

Reset
REQ-019 While rst=1, the following SHALL hold on the next edge:
- state = ACCUM, C = 0, latched tuser = 0.
- output_axis_tvalid, tdata, tkeep, tlast, tuser = 0.
- input_axis_tready = 0 for the whole time rst is high.
REQ-020 Reset asserted mid-frame SHALL discard buffered bytes and any pending output beat without emitting a tlast beat.

Verification
REQ-021 K=8, input frame of 3 beats, tkeep 0xFF each, output_axis_tready=1 -> 3 output beats of tkeep 0xFF on consecutive cycles; third has tlast=1; data identical.
REQ-022 Two beats, tkeep 0x0F then 0xF0 with tlast, tuser=1 -> one beat, tkeep 0xFF, bytes = lanes 0-3 of beat 1 followed by lanes 4-7 of beat 2, tlast=1, tuser=1.
REQ-023 Beats with tkeep 0xFF, 0xFF, then 0x00 with tlast -> two full beats with tlast=0, then a beat with tkeep=0 and tlast=1.
REQ-024 tkeep 0xFF, then 0x07 with tlast, while output_axis_tready is held 0 for 5 cycles -> input_axis_tready drops, outputs stay stable, then 0xFF (tlast=0) and 0x07 (tlast=1) are emitted.
REQ-025 Single beat, tkeep 0x00, tlast=1 -> one beat with tkeep=0, tlast=1.
REQ-026 rst pulsed after accepting tkeep 0x3F without tlast -> no output beat; the next frame of tkeep 0xFF with tlast yields exactly one beat of 0xFF with tlast=1.
